// File: rtl/rtlinf_act_reader.sv
// rtlinf_act_reader: takes ownership of one activation memory through the
// local external port (index NUM_KERNELS), issues a burst of act_read
// requests under a credit limit and streams the returned words out on a
// valid/ready interface with a last marker.
// Optional build macro: RTLINF_ACT_READER_ABORT_EN adds an i_abort input
// that stops a running burst, flushes the buffer and releases the memory.
module rtlinf_act_reader #(
  parameter int GROUP_SIZE           = 4,
  parameter int DATA_WIDTH           = 8,
  parameter int NUM_KERNELS          = 4,
  parameter int LOG_NUM_KERNELS      = 2,
  parameter int LOG_NUM_ACT_MEMORIES = 1,
  parameter int LOG_MAX_ADDRESS      = 10,
  parameter int FIFO_DEPTH           = 4,
  parameter int LOG_FIFO_DEPTH       = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
`ifdef RTLINF_ACT_READER_ABORT_EN
  input  logic                                 i_abort,
`endif
  input  logic                                 i_start,
  input  logic [LOG_NUM_ACT_MEMORIES-1:0]      i_start_memory,
  input  logic [LOG_MAX_ADDRESS-1:0]           i_start_addr,
  input  logic [LOG_MAX_ADDRESS:0]             i_num_words,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_cmd_act_assign,
  output logic                                 o_cmd_act_unassign,
  output logic [LOG_NUM_KERNELS:0]             o_cmd_act_read_port,
  output logic [LOG_NUM_KERNELS:0]             o_cmd_act_write_port,
  output logic [LOG_NUM_ACT_MEMORIES-1:0]      o_cmd_act_memory,
  output logic                                 o_act_read,
  output logic [LOG_MAX_ADDRESS-1:0]           o_act_read_addr,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0]     i_act_read_data,
  input  logic                                 i_act_read_valid,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0]     o_out_data,
  output logic                                 o_out_valid,
  input  logic                                 i_out_ready,
  output logic                                 o_out_last,
  output logic                                 o_err
);

  localparam int AW = LOG_MAX_ADDRESS;
  localparam int CW = LOG_MAX_ADDRESS + 1;
  localparam int WW = GROUP_SIZE * DATA_WIDTH;
  localparam int FW = LOG_FIFO_DEPTH;
  localparam int PW = LOG_NUM_KERNELS + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ASSIGN, S_SETTLE, S_READ, S_DRAIN, S_UNASSIGN, S_DONE
  } state_t;

  state_t                          r_state, w_state_next;
  logic [LOG_NUM_ACT_MEMORIES-1:0] r_mem;
  logic [AW-1:0]                   r_addr;
  logic [CW-1:0]                   r_remaining, r_num_words, r_returned;
  logic [FW:0]                     r_outstanding, r_count;
  logic [FW-1:0]                   r_wr_ptr, r_rd_ptr;
  logic                            r_aborting, r_err;
  logic [WW-1:0]                   r_fifo_data [FIFO_DEPTH];
  logic                            r_fifo_last [FIFO_DEPTH];

  logic w_abort, w_credit, w_issue, w_ret, w_push, w_pop, w_push_last;
  logic w_out_valid, w_cmd;

`ifdef RTLINF_ACT_READER_ABORT_EN
  assign w_abort = i_abort && ((r_state == S_READ) || (r_state == S_DRAIN));
`else
  assign w_abort = 1'b0;
`endif

  // Credit covers both in-flight reads and buffered words, so every return has a slot.
  assign w_credit    = ({1'b0, r_outstanding} + {1'b0, r_count}) < (FW+2)'(FIFO_DEPTH);
  assign w_issue     = (r_state == S_READ) && (r_remaining != '0) && w_credit
                       && !r_aborting && !w_abort;
  assign w_ret       = i_act_read_valid && (r_outstanding != '0);
  assign w_push      = w_ret && !r_aborting && !w_abort;
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid && i_out_ready && !w_abort;
  assign w_push_last = (r_returned == (r_num_words - CW'(1)));
  assign w_cmd       = o_cmd_act_assign || o_cmd_act_unassign;

  assign o_busy               = (r_state != S_IDLE);
  assign o_done               = (r_state == S_DONE);
  assign o_cmd_act_assign     = (r_state == S_ASSIGN);
  assign o_cmd_act_unassign   = (r_state == S_UNASSIGN);
  assign o_cmd_act_read_port  = w_cmd ? PW'(NUM_KERNELS) : '0;
  assign o_cmd_act_write_port = w_cmd ? PW'(NUM_KERNELS) : '0;
  assign o_cmd_act_memory     = w_cmd ? r_mem : '0;
  assign o_act_read           = w_issue;
  assign o_act_read_addr      = w_issue ? r_addr : '0;
  assign o_out_valid          = w_out_valid;
  assign o_out_data           = w_out_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign o_out_last           = w_out_valid && r_fifo_last[r_rd_ptr];
  assign o_err                = r_err;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_state_next = S_ASSIGN;
      S_ASSIGN:   w_state_next = S_SETTLE;
      S_SETTLE:   w_state_next = (r_remaining == '0) ? S_UNASSIGN : S_READ;
      S_READ:     if (w_abort || (w_issue && (r_remaining == CW'(1))))
                    w_state_next = S_DRAIN;
      S_DRAIN:    if (!w_abort && (r_outstanding == '0) && (r_count == '0))
                    w_state_next = S_UNASSIGN;
      S_UNASSIGN: w_state_next = S_DONE;
      S_DONE:     w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Burst bookkeeping: latched request, address/count progress, in-flight reads, error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem         <= '0;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_num_words   <= '0;
      r_returned    <= '0;
      r_outstanding <= '0;
      r_aborting    <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_mem       <= i_start_memory;
        r_addr      <= i_start_addr;
        r_remaining <= i_num_words;
        r_num_words <= i_num_words;
        r_returned  <= '0;
        r_aborting  <= 1'b0;
      end else begin
        if (w_issue) begin
          r_addr      <= r_addr + AW'(1);
          r_remaining <= r_remaining - CW'(1);
        end
        if (w_push)  r_returned <= r_returned + CW'(1);
        if (w_abort) r_aborting <= 1'b1;
      end
      case ({w_issue, w_ret})
        2'b10:   r_outstanding <= r_outstanding + (FW+1)'(1);
        2'b01:   r_outstanding <= r_outstanding - (FW+1)'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (i_act_read_valid && (r_outstanding == '0)) r_err <= 1'b1;
    end
  end

  // Output buffer pointers and occupancy; an abort empties it in one step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_abort) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FW+1)'(1);
        2'b01:   r_count <= r_count - (FW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage with the per-entry last marker; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= i_act_read_data;
      r_fifo_last[r_wr_ptr] <= w_push_last;
    end
  end

endmodule

// File: tb/tb_rtlinf_act_reader.sv
// Directed bench for rtlinf_act_reader with a 2-cycle-latency memory model.
module tb_rtlinf_act_reader;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [0:0]  start_memory;
  logic [9:0]  start_addr;
  logic [10:0] num_words;
  logic        busy, done, cmd_act_assign, cmd_act_unassign;
  logic [2:0]  cmd_act_read_port, cmd_act_write_port;
  logic [0:0]  cmd_act_memory;
  logic        act_read;
  logic [9:0]  act_read_addr;
  logic [31:0] act_read_data;
  logic        act_read_valid;
  logic [31:0] out_data;
  logic        out_valid, out_ready, out_last, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rtlinf_act_reader dut (
    .i_clk(clk), .i_rst_n(rst_n),
`ifdef RTLINF_ACT_READER_ABORT_EN
    .i_abort(abort),
`endif
    .i_start(start), .i_start_memory(start_memory), .i_start_addr(start_addr),
    .i_num_words(num_words), .o_busy(busy), .o_done(done),
    .o_cmd_act_assign(cmd_act_assign), .o_cmd_act_unassign(cmd_act_unassign),
    .o_cmd_act_read_port(cmd_act_read_port), .o_cmd_act_write_port(cmd_act_write_port),
    .o_cmd_act_memory(cmd_act_memory), .o_act_read(act_read),
    .o_act_read_addr(act_read_addr), .i_act_read_data(act_read_data),
    .i_act_read_valid(act_read_valid), .o_out_data(out_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_last(out_last),
    .o_err(err)
  );

  // Memory model: fixed two-cycle read latency, stray valid injectable.
  logic [31:0] mem_model [1024];
  logic        p0_v, p1_v, stray_valid;
  logic [9:0]  p0_a;
  logic [31:0] p1_d;
  always @(posedge clk) begin
    if (!rst_n) begin
      p0_v <= 1'b0; p1_v <= 1'b0; p0_a <= '0; p1_d <= '0;
    end else begin
      p0_v <= act_read; p0_a <= act_read_addr;
      p1_v <= p0_v;     p1_d <= mem_model[p0_a];
    end
  end
  assign act_read_valid = p1_v | stray_valid;
  assign act_read_data  = p1_d;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Backpressure pattern 1,0,0,1 applied just after each edge.
  logic toggle_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (toggle_en) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
  end

  // Monitor state.
  logic [31:0] beat_d[$];
  logic        beat_l[$];
  logic [9:0]  addr_q[$];
  int assign_cnt, unassign_cnt, done_cnt, ov_cnt, post_ov_cnt, cmd_bad, occ_viol;
  int assign_cyc, unassign_cyc, done_cyc, first_rd_cyc, tb_out, tb_fifo;
  logic done_seen, post_abort, occ_chk;
  logic [0:0] exp_mem;

  always @(negedge clk) begin
    if (!rst_n) begin
      tb_out = 0; tb_fifo = 0;
    end else begin
      automatic bit ret = act_read_valid && (tb_out > 0);
      automatic bit pop = out_valid && out_ready;
      if (occ_chk && (tb_out + tb_fifo > 4)) occ_viol++;
      if (act_read) begin
        addr_q.push_back(act_read_addr);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (pop) begin beat_d.push_back(out_data); beat_l.push_back(out_last); end
      if (out_valid) ov_cnt++;
      if (out_valid && post_abort) post_ov_cnt++;
      tb_out  = tb_out + int'(act_read) - int'(ret);
      tb_fifo = tb_fifo + int'(ret) - int'(pop);
      if (cmd_act_assign)   begin assign_cnt++;   assign_cyc = cyc;   end
      if (cmd_act_unassign) begin unassign_cnt++; unassign_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; done_seen = 1'b1; end
      if (cmd_act_assign || cmd_act_unassign) begin
        if (cmd_act_read_port !== 3'd4 || cmd_act_write_port !== 3'd4 || cmd_act_memory !== exp_mem)
          cmd_bad++;
      end else if (cmd_act_read_port !== 3'd0 || cmd_act_write_port !== 3'd0 || cmd_act_memory !== 1'b0)
        cmd_bad++;
    end
  end

  task automatic mon_clear();
    beat_d.delete(); beat_l.delete(); addr_q.delete();
    assign_cnt = 0; unassign_cnt = 0; done_cnt = 0; ov_cnt = 0; post_ov_cnt = 0;
    cmd_bad = 0; occ_viol = 0; assign_cyc = -1; unassign_cyc = -1; done_cyc = -1;
    first_rd_cyc = -1; done_seen = 1'b0; post_abort = 1'b0; occ_chk = 1'b0;
  endtask

  // Pulses start; returns the cycle-1 index (cycle in which assign is expected).
  task automatic kick(input logic [0:0] m, input int a, input int n, output int c0);
    exp_mem = m; start_memory = m; start_addr = 10'(a); num_words = 11'(n);
    @(posedge clk); #1; start = 1'b1; c0 = cyc + 1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 600 && !done_seen; k++) @(posedge clk);
    n_cmp++;
    if (!done_seen) begin n_bad++; $display("FAIL %s_timeout: done=0 required done=1", name); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stray_valid = 1'b0; out_ready = 1'b1;
    start_memory = '0; start_addr = '0; num_words = '0; exp_mem = '0;
    mon_clear();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, cmd_act_assign, cmd_act_unassign, act_read, out_valid, out_last, err} !== 8'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b required 00000000",
        {busy, done, cmd_act_assign, cmd_act_unassign, act_read, out_valid, out_last, err});
    end
    n_cmp++;
    if (out_data !== 32'h0 || act_read_addr !== 10'h0) begin
      n_bad++; $display("FAIL reset_data: out_data=%h addr=%0d required 0/0", out_data, act_read_addr);
    end
    n_cmp++;
    if (cmd_act_read_port !== 3'd0 || cmd_act_write_port !== 3'd0 || cmd_act_memory !== 1'b0) begin
      n_bad++; $display("FAIL reset_cmd: rp=%0d wp=%0d mem=%0d required 0", cmd_act_read_port, cmd_act_write_port, cmd_act_memory);
    end
    rst_n = 1'b1;
    $display("reset: outputs checked at zero");
  endtask

  task automatic test_basic();
    int c0;
    mon_clear(); out_ready = 1'b1;
    kick(1'b0, 0, 16, c0);
    wait_done("basic");
    n_cmp++;
    if (beat_d.size() != 16) begin n_bad++; $display("FAIL basic_count: got %0d required 16", beat_d.size()); end
    for (int i = 0; i < beat_d.size(); i++) begin
      n_cmp++;
      if (beat_d[i] !== mem_model[i] || beat_l[i] !== (i == 15)) begin
        n_bad++; $display("FAIL basic_beat%0d: got %h last=%b required %h last=%b", i, beat_d[i], beat_l[i], mem_model[i], (i == 15));
      end
    end
    n_cmp++;
    if (beat_d.size() == 16 && (beat_d[0] !== 32'h03020100 || beat_d[15] !== 32'h3f3e3d3c)) begin
      n_bad++; $display("FAIL basic_ends: got %h..%h required 03020100..3f3e3d3c", beat_d[0], beat_d[15]);
    end
    n_cmp++;
    if (assign_cyc - c0 != 0 || first_rd_cyc - c0 != 2) begin
      n_bad++; $display("FAIL basic_timing: assign cycle %0d first read cycle %0d required 1/3", assign_cyc - c0 + 1, first_rd_cyc - c0 + 1);
    end
    n_cmp++;
    if (done_cyc != unassign_cyc + 1 || assign_cnt != 1 || unassign_cnt != 1 || done_cnt != 1) begin
      n_bad++; $display("FAIL basic_cmds: done@%0d unassign@%0d a=%0d u=%0d d=%0d required done=unassign+1, 1/1/1",
        done_cyc, unassign_cyc, assign_cnt, unassign_cnt, done_cnt);
    end
    n_cmp++;
    if (cmd_bad != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_ports: cmd_bad=%0d busy=%b required 0/0", cmd_bad, busy);
    end
    $display("basic: %0d beats, %0d reads", beat_d.size(), addr_q.size());
  endtask

  task automatic test_backpressure();
    int c0;
    mon_clear(); occ_chk = 1'b1; toggle_en = 1'b1;
    kick(1'b0, 0, 16, c0);
    wait_done("bp");
    toggle_en = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (beat_d.size() != 16) begin n_bad++; $display("FAIL bp_count: got %0d required 16", beat_d.size()); end
    for (int i = 0; i < beat_d.size(); i++) begin
      n_cmp++;
      if (beat_d[i] !== mem_model[i] || beat_l[i] !== (i == 15)) begin
        n_bad++; $display("FAIL bp_beat%0d: got %h last=%b required %h last=%b", i, beat_d[i], beat_l[i], mem_model[i], (i == 15));
      end
    end
    n_cmp++;
    if (occ_viol != 0) begin n_bad++; $display("FAIL bp_credit: %0d cycles over 4 required 0", occ_viol); end
    $display("backpressure: %0d beats, credit violations %0d", beat_d.size(), occ_viol);
  endtask

  task automatic test_wrap();
    int c0;
    logic [9:0] exp_a [4];
    exp_a[0] = 10'd1022; exp_a[1] = 10'd1023; exp_a[2] = 10'd0; exp_a[3] = 10'd1;
    mon_clear(); out_ready = 1'b1;
    kick(1'b1, 1022, 4, c0);
    wait_done("wrap");
    n_cmp++;
    if (addr_q.size() != 4 || beat_d.size() != 4) begin
      n_bad++; $display("FAIL wrap_count: reads %0d beats %0d required 4/4", addr_q.size(), beat_d.size());
    end
    for (int i = 0; i < addr_q.size() && i < 4; i++) begin
      n_cmp++;
      if (addr_q[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_addr%0d: got %0d required %0d", i, addr_q[i], exp_a[i]); end
    end
    for (int i = 0; i < beat_d.size() && i < 4; i++) begin
      n_cmp++;
      if (beat_d[i] !== mem_model[exp_a[i]] || beat_l[i] !== (i == 3)) begin
        n_bad++; $display("FAIL wrap_beat%0d: got %h last=%b required %h last=%b", i, beat_d[i], beat_l[i], mem_model[exp_a[i]], (i == 3));
      end
    end
    n_cmp++;
    if (cmd_bad != 0) begin n_bad++; $display("FAIL wrap_mem: cmd_bad=%0d required 0", cmd_bad); end
    $display("wrap: reads %0d beats %0d", addr_q.size(), beat_d.size());
  endtask

  task automatic test_zero();
    int c0;
    mon_clear(); out_ready = 1'b1;
    kick(1'b0, 5, 0, c0);
    wait_done("zero");
    n_cmp++;
    if (addr_q.size() != 0 || ov_cnt != 0) begin
      n_bad++; $display("FAIL zero_traffic: reads %0d valid cycles %0d required 0/0", addr_q.size(), ov_cnt);
    end
    n_cmp++;
    if (assign_cyc - c0 != 0 || unassign_cyc - c0 != 2 || done_cyc - c0 != 3) begin
      n_bad++; $display("FAIL zero_seq: assign %0d unassign %0d done %0d required cycles 1/3/4",
        assign_cyc - c0 + 1, unassign_cyc - c0 + 1, done_cyc - c0 + 1);
    end
    $display("zero: assign/unassign/done %0d/%0d/%0d", assign_cnt, unassign_cnt, done_cnt);
  endtask

  task automatic test_abort();
`ifdef RTLINF_ACT_READER_ABORT_EN
    int c0;
    bit hit = 1'b0;
    mon_clear(); out_ready = 1'b1;
    kick(1'b0, 0, 16, c0);
    for (int k = 0; k < 200 && !hit; k++) begin
      @(posedge clk); #1;
      if (beat_d.size() >= 5) begin hit = 1'b1; out_ready = 1'b0; abort = 1'b1; end
    end
    @(posedge clk); #1;
    abort = 1'b0; post_abort = 1'b1; out_ready = 1'b1;
    wait_done("abort");
    n_cmp++;
    if (beat_d.size() != 5 || post_ov_cnt != 0) begin
      n_bad++; $display("FAIL abort_beats: beats %0d valid after abort %0d required 5/0", beat_d.size(), post_ov_cnt);
    end
    n_cmp++;
    if (unassign_cnt != 1 || done_cnt != 1 || done_cyc != unassign_cyc + 1) begin
      n_bad++; $display("FAIL abort_release: u=%0d d=%0d required 1/1 adjacent", unassign_cnt, done_cnt);
    end
    for (int i = 0; i < beat_l.size(); i++) begin
      n_cmp++;
      if (beat_l[i] !== 1'b0) begin n_bad++; $display("FAIL abort_last%0d: got 1 required 0", i); end
    end
    $display("abort: beats %0d", beat_d.size());
`endif
  endtask

  task automatic test_reset_mid();
    int c0;
    mon_clear(); out_ready = 1'b1;
    kick(1'b0, 0, 16, c0);
    repeat (6) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    n_cmp++;
    if ({busy, done, cmd_act_assign, cmd_act_unassign, act_read, out_valid, out_last, err} !== 8'b0 || out_data !== 32'h0) begin
      n_bad++; $display("FAIL midrst_outputs: got %b data %h required 0",
        {busy, done, cmd_act_assign, cmd_act_unassign, act_read, out_valid, out_last, err}, out_data);
    end
    n_cmp++;
    if (unassign_cnt != 0) begin n_bad++; $display("FAIL midrst_unassign: got %0d required 0", unassign_cnt); end
    @(posedge clk); #1; rst_n = 1'b1;
    mon_clear();
    kick(1'b0, 0, 16, c0);
    wait_done("midrst");
    n_cmp++;
    if (beat_d.size() != 16 || err !== 1'b0) begin
      n_bad++; $display("FAIL midrst_rerun: beats %0d err %b required 16/0", beat_d.size(), err);
    end
    for (int i = 0; i < beat_d.size(); i++) begin
      n_cmp++;
      if (beat_d[i] !== mem_model[i]) begin n_bad++; $display("FAIL midrst_beat%0d: got %h required %h", i, beat_d[i], mem_model[i]); end
    end
    $display("reset mid-burst: rerun beats %0d", beat_d.size());
  endtask

  task automatic test_stray();
    @(posedge clk); #1; stray_valid = 1'b1;
    @(posedge clk); #1; stray_valid = 1'b0;
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL stray_err: got %b required 1", err); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL stray_sticky: err %b busy %b required 1/0", err, busy); end
    $display("stray: err=%b", err);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem_model[a] = 32'hA5000000 | 32'(a);
    for (int i = 0; i < 16; i++)
      mem_model[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_abort();
    test_reset_mid();
    test_stray();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
